// File: rtl/csr_file.sv
// Machine-mode CSR unit: Zicsr decode, machine CSR state, cycle/instret counters,
// trap entry and mret. Reads are combinational; all state changes on the rising edge.
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int unsigned COUNTER_W   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csrValid,
  input  logic [2:0]  funct3,
  input  logic [11:0] csrAddr,
  input  logic [31:0] rs1Data,
  input  logic [4:0]  rs1Uimm,
  input  logic [4:0]  rd,
  output logic [31:0] rdData,
  output logic        rdWrite,
  output logic        illegal,
  input  logic        instRetire,
  input  logic        trapValid,
  input  logic [31:0] trapCause,
  input  logic [31:0] trapPc,
  input  logic        mretValid,
  output logic [31:0] trapVector,
  output logic [31:0] epcOut,
  output logic        mieOut
);

  localparam logic [COUNTER_W-1:0] CntOne = COUNTER_W'(1);

  logic                 mieQ, mpieQ;
  logic [31:0]          mtvecQ, mepcQ, mcauseQ, mscratchQ;
  logic [COUNTER_W-1:0] mcycleQ, minstretQ;

  logic [1:0]  op;
  logic [31:0] src, oldVal, newVal;
  logic        readReq, writeReq, mapped, readOnly, doWrite;
  logic [63:0] cycleExt, instretExt;

  assign op         = funct3[1:0];
  assign src        = funct3[2] ? {27'b0, rs1Uimm} : rs1Data;
  assign readReq    = (op == 2'b01) ? (rd != 5'd0) : 1'b1;
  assign writeReq   = (op == 2'b01) ? 1'b1 : (rs1Uimm != 5'd0);
  // Counters are zero-extended so the *h views read 0 above COUNTER_W.
  assign cycleExt   = 64'(mcycleQ);
  assign instretExt = 64'(minstretQ);

  always_comb begin
    mapped = 1'b1;
    oldVal = '0;
    case (csrAddr)
      12'h300:          oldVal = {24'b0, mpieQ, 3'b0, mieQ, 3'b0};
      12'h301:          oldVal = MISA_VAL;
      12'h305:          oldVal = mtvecQ;
      12'h340:          oldVal = mscratchQ;
      12'h341:          oldVal = mepcQ;
      12'h342:          oldVal = mcauseQ;
      12'hB00, 12'hC00: oldVal = cycleExt[31:0];
      12'hB80, 12'hC80: oldVal = cycleExt[63:32];
      12'hB02, 12'hC02: oldVal = instretExt[31:0];
      12'hB82, 12'hC82: oldVal = instretExt[63:32];
      12'hF14:          oldVal = HART_ID;
      default:          mapped = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      2'b10:   newVal = oldVal | src;
      2'b11:   newVal = oldVal & ~src;
      default: newVal = src;
    endcase
  end

  assign readOnly = (csrAddr[11:10] == 2'b11) || (csrAddr == 12'h301);
  assign illegal  = csrValid & (~mapped | (op == 2'b00) | (writeReq & readOnly));
  assign rdWrite  = csrValid & readReq & ~illegal;
  assign rdData   = rdWrite ? oldVal : 32'h0;
  assign doWrite  = csrValid & writeReq & ~illegal;

  assign trapVector = mtvecQ;
  assign epcOut     = mepcQ;
  assign mieOut     = mieQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      mieQ      <= 1'b0;
      mpieQ     <= 1'b0;
      mtvecQ    <= {MTVEC_RESET[31:2], 2'b00};
      mepcQ     <= '0;
      mcauseQ   <= '0;
      mscratchQ <= '0;
      mcycleQ   <= '0;
      minstretQ <= '0;
    end else begin
      mcycleQ <= mcycleQ + CntOne;
      if (instRetire) minstretQ <= minstretQ + CntOne;
      // A CSR write loses to trap/mret only on the fields those events touch.
      if (doWrite) begin
        case (csrAddr)
          12'h300: if (!trapValid && !mretValid) begin
            mieQ  <= newVal[3];
            mpieQ <= newVal[7];
          end
          12'h305: mtvecQ    <= {newVal[31:2], 2'b00};
          12'h340: mscratchQ <= newVal;
          12'h341: if (!trapValid) mepcQ <= {newVal[31:2], 2'b00};
          12'h342: if (!trapValid) mcauseQ <= newVal;
          12'hB00: mcycleQ   <= {mcycleQ[COUNTER_W-1:32], newVal};
          12'hB80: mcycleQ   <= {newVal[COUNTER_W-33:0], mcycleQ[31:0]};
          12'hB02: minstretQ <= {minstretQ[COUNTER_W-1:32], newVal};
          12'hB82: minstretQ <= {newVal[COUNTER_W-33:0], minstretQ[31:0]};
          default: ;
        endcase
      end
      if (trapValid) begin
        mepcQ   <= {trapPc[31:2], 2'b00};
        mcauseQ <= trapCause;
        mpieQ   <= mieQ;
        mieQ    <= 1'b0;
      end else if (mretValid) begin
        mieQ  <= mpieQ;
        mpieQ <= 1'b1;
      end
    end
  end

endmodule
